// File: rtl/data_mem_dma.sv
// Block-copy engine that drives the data-memory port: copies len words from src to dst, two cycles per word.
// Optional fill mode (constant write, one cycle per word) is compiled in with DATA_DMA_FILL_EN.
module data_mem_dma #(
    parameter int ADDRESS_BITS = 11,
    parameter int DATA_BITS    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    // Request handshake: i_start is taken only in IDLE or DONE; o_busy high means a pulse is ignored.
    input  logic                    i_start,
    input  logic [ADDRESS_BITS-1:0] i_src,
    input  logic [ADDRESS_BITS-1:0] i_dst,
    input  logic [ADDRESS_BITS:0]   i_len,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic [ADDRESS_BITS-1:0] o_mem_address,
    output logic [DATA_BITS-1:0]    o_mem_data,
    output logic [1:0]              o_dbg_state,
    input  logic [DATA_BITS-1:0]    i_mem_data
`ifdef DATA_DMA_FILL_EN
    ,
    input  logic                    i_fill,
    input  logic [DATA_BITS-1:0]    i_fill_value
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDRESS_BITS-1:0] ADDR_ONE = 1;
    localparam logic [ADDRESS_BITS:0]   CNT_ONE  = 1;
    localparam logic [ADDRESS_BITS:0]   CNT_ZERO = '0;

    state_t                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] src_q, src_d;
    logic [ADDRESS_BITS-1:0] dst_q, dst_d;
    logic [ADDRESS_BITS:0]   cnt_q, cnt_d;
    logic [DATA_BITS-1:0]    buf_q, buf_d;
    logic                    fill_q, fill_d;
    logic [DATA_BITS-1:0]    fill_val_q, fill_val_d;

    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0]    wdata_q, wdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            fill_q     <= 1'b0;
            fill_val_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            fill_val_q <= fill_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next state and pointer updates.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        fill_d     = fill_q;
        fill_val_d = fill_val_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (i_start) begin
                    src_d = i_src;
                    dst_d = i_dst;
                    cnt_d = i_len;
`ifdef DATA_DMA_FILL_EN
                    fill_d     = i_fill;
                    fill_val_d = i_fill_value;
`else
                    fill_d     = 1'b0;
                    fill_val_d = '0;
`endif
                    if (i_len == CNT_ZERO) begin
                        state_d = DONE;
                    end else if (fill_d) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                buf_d   = i_mem_data;
                state_d = WRITE;
            end
            WRITE: begin
                dst_d = dst_q + ADDR_ONE;
                if (!fill_q) begin
                    src_d = src_q + ADDR_ONE;
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end else if (fill_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they line up with it once registered.
    always_comb begin
        busy_d  = (state_d == READ) || (state_d == WRITE);
        done_d  = (state_d == DONE);
        rd_d    = (state_d == READ);
        wr_d    = (state_d == WRITE);
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_d == READ) begin
            addr_d = src_d;
        end else if (state_d == WRITE) begin
            addr_d  = dst_d;
            wdata_d = fill_d ? fill_val_d : buf_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_mem_read    = rd_q;
    assign o_mem_write   = wr_q;
    assign o_mem_address = addr_q;
    assign o_mem_data    = wdata_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_data_mem_dma.sv
// Directed bench for data_mem_dma with a falling-edge data memory model.
module tb_data_mem_dma;
    localparam int AB = 11;
    localparam int DB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [AB-1:0] i_src = '0;
    logic [AB-1:0] i_dst = '0;
    logic [AB:0]   i_len = '0;
    logic          o_busy, o_done, o_mem_read, o_mem_write;
    logic [AB-1:0] o_mem_address;
    logic [DB-1:0] o_mem_data;
    logic [1:0]    o_dbg_state;
    logic [DB-1:0] rd_data = '0;
`ifdef DATA_DMA_FILL_EN
    logic          i_fill = 1'b0;
    logic [DB-1:0] i_fill_value = '0;
`endif

    logic [DB-1:0] mem [0:(1<<AB)-1];
    logic          poke_en = 1'b0;
    logic [AB-1:0] poke_addr = '0;
    logic [DB-1:0] poke_data = '0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_dma #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) dut (
        .clk(clk),
        .rst(rst),
        .i_start(i_start),
        .i_src(i_src),
        .i_dst(i_dst),
        .i_len(i_len),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write),
        .o_mem_address(o_mem_address),
        .o_mem_data(o_mem_data),
        .o_dbg_state(o_dbg_state),
        .i_mem_data(rd_data)
`ifdef DATA_DMA_FILL_EN
        ,
        .i_fill(i_fill),
        .i_fill_value(i_fill_value)
`endif
    );

    // Memory commands are captured on the falling edge.
    always @(negedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (o_mem_write) begin
            mem[o_mem_address] <= o_mem_data;
        end
        if (o_mem_read) begin
            rd_data <= mem[o_mem_address];
            rd_cnt  <= rd_cnt + 1;
        end
        if (o_mem_write) wr_cnt <= wr_cnt + 1;
        if (o_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AB-1:0] a, input logic [DB-1:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    // Returns in cycle 1 after the accept edge.
    task automatic start_xfer(input logic [AB-1:0] s, input logic [AB-1:0] d, input logic [AB:0] n);
        i_src   = s;
        i_dst   = d;
        i_len   = n;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int cyc_now, input int exp_cyc);
        int cyc = cyc_now;
        while (!o_done && cyc < 100) begin
            step();
            cyc++;
        end
        chk(tag, cyc, exp_cyc);
    endtask

    initial begin
        int d0, r0, w0;

        // Reset state
        step();
        step();
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_read", o_mem_read, 0);
        chk("rst_write", o_mem_write, 0);
        chk("rst_addr", o_mem_address, 0);
        chk("rst_data", o_mem_data, 0);
        chk("rst_state", o_dbg_state, 0);
        rst = 1'b0;
        step();

        // Basic copy of four words
        for (int k = 0; k < 4; k++) poke(AB'(16 + k), DB'(16'hA000 + k));
        start_xfer(11'h010, 11'h100, 12'd4);
        for (int c = 1; c <= 9; c++) begin
            chk("t1_busy", o_busy, c <= 8);
            chk("t1_done", o_done, c == 9);
            chk("t1_read", o_mem_read, (c <= 8) && (c % 2 == 1));
            chk("t1_write", o_mem_write, (c <= 8) && (c % 2 == 0));
            if (c <= 8 && c % 2 == 1) chk("t1_raddr", o_mem_address, 32'h010 + (c - 1) / 2);
            if (c <= 8 && c % 2 == 0) begin
                chk("t1_waddr", o_mem_address, 32'h100 + (c - 2) / 2);
                chk("t1_wdata", o_mem_data, 32'hA000 + (c - 2) / 2);
            end
            if (c < 9) step();
        end
        step();
        chk("t1_done_clear", o_done, 0);
        chk("t1_idle", o_dbg_state, 0);
        chk("t1_mem0", mem[11'h100], 32'hA000);
        chk("t1_mem1", mem[11'h101], 32'hA001);
        chk("t1_mem2", mem[11'h102], 32'hA002);
        chk("t1_mem3", mem[11'h103], 32'hA003);

        // Zero-length request
        r0 = rd_cnt;
        w0 = wr_cnt;
        start_xfer(11'h010, 11'h180, 12'd0);
        chk("t2_done", o_done, 1);
        chk("t2_busy", o_busy, 0);
        chk("t2_read", o_mem_read, 0);
        chk("t2_write", o_mem_write, 0);
        step();
        chk("t2_done_clear", o_done, 0);
        chk("t2_busy2", o_busy, 0);
        step();
        chk("t2_rd_cnt", rd_cnt - r0, 0);
        chk("t2_wr_cnt", wr_cnt - w0, 0);

        // Wrap-around with forward overlap
        poke(11'h7FE, 16'h1111);
        poke(11'h7FF, 16'h2222);
        poke(11'h000, 16'h3333);
        poke(11'h001, 16'h0000);
        start_xfer(11'h7FE, 11'h7FF, 12'd3);
        wait_done("t3_done_cycle", 1, 7);
        step();
        chk("t3_mem7ff", mem[11'h7FF], 32'h1111);
        chk("t3_mem000", mem[11'h000], 32'h1111);
        chk("t3_mem001", mem[11'h001], 32'h1111);
        chk("t3_mem7fe", mem[11'h7FE], 32'h1111);

        // Start pulse while busy is ignored
        poke(11'h200, 16'h5555);
        poke(11'h400, 16'h7777);
        d0 = done_cnt;
        start_xfer(11'h010, 11'h120, 12'd4);
        step();
        step();
        i_src   = 11'h200;
        i_dst   = 11'h400;
        i_len   = 12'd1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("t4_write_c4", o_mem_write, 1);
        chk("t4_waddr_c4", o_mem_address, 32'h121);
        chk("t4_wdata_c4", o_mem_data, 32'hA001);
        wait_done("t4_done_cycle", 4, 9);
        step();
        step();
        step();
        chk("t4_done_count", done_cnt - d0, 1);
        chk("t4_busy_after", o_busy, 0);
        chk("t4_mem0", mem[11'h120], 32'hA000);
        chk("t4_mem3", mem[11'h123], 32'hA003);
        chk("t4_mem400", mem[11'h400], 32'h7777);

        // Reset mid-transfer
        poke(11'h140, 16'h0000);
        poke(11'h141, 16'h0000);
        d0 = done_cnt;
        w0 = wr_cnt;
        start_xfer(11'h010, 11'h140, 12'd4);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t5_busy", o_busy, 0);
        chk("t5_read", o_mem_read, 0);
        chk("t5_write", o_mem_write, 0);
        chk("t5_addr", o_mem_address, 0);
        chk("t5_data", o_mem_data, 0);
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("t5_wr_cnt", wr_cnt - w0, 1);
        chk("t5_done_cnt", done_cnt - d0, 0);
        chk("t5_mem140", mem[11'h140], 32'hA000);
        chk("t5_mem141", mem[11'h141], 32'h0000);
        start_xfer(11'h013, 11'h150, 12'd1);
        wait_done("t5_restart_done", 1, 3);
        step();
        chk("t5_mem150", mem[11'h150], 32'hA003);

`ifdef DATA_DMA_FILL_EN
        // Fill mode
        r0 = rd_cnt;
        i_fill       = 1'b1;
        i_fill_value = 16'hBEEF;
        start_xfer(11'h300, 11'h300, 12'd5);
        i_fill = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk("t6_busy", o_busy, c <= 5);
            chk("t6_done", o_done, c == 6);
            chk("t6_write", o_mem_write, c <= 5);
            if (c <= 5) chk("t6_waddr", o_mem_address, 32'h300 + c - 1);
            if (c < 6) step();
        end
        step();
        chk("t6_rd_cnt", rd_cnt - r0, 0);
        for (int k = 0; k < 5; k++) chk("t6_mem", mem[AB'(12'h300 + k)], 32'hBEEF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
